// File: rtl/mem_arbiter.sv
// Two-port arbiter sharing one single-port RAM between instruction fetch (imem) and data (dmem).
// dmem wins contested cycles until imem has lost STARVE_LIMIT times in a row.
module mem_arbiter #(
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   input  logic              imem_req_i,
   input  logic [ADDR_W-1:0] imem_addr_i,
   output logic              imem_gnt_o,
   output logic              imem_rvalid_o,
   output logic [31:0]       imem_rdata_o,
   input  logic              dmem_req_i,
   input  logic [ADDR_W-1:0] dmem_addr_i,
   input  logic [31:0]       dmem_wdata_i,
   input  logic [3:0]        dmem_wmask_i,
   output logic              dmem_gnt_o,
   output logic              dmem_rvalid_o,
   output logic [31:0]       dmem_rdata_o,
   output logic              mem_en_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_wmask_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   localparam int               CNT_W   = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      RESP_NONE = 2'd0,
      RESP_IMEM = 2'd1,
      RESP_DMEM = 2'd2
   } resp_t;

   resp_t            resp_r;
   resp_t            resp_next;
   logic [CNT_W-1:0] starve_cnt;
   logic [CNT_W-1:0] starve_cnt_next;
   logic             contested;
   logic             imem_gnt;
   logic             dmem_gnt;

   // Grants are gated by reset so nothing reaches the RAM while reset is held.
   always_comb begin
      contested = imem_req_i & dmem_req_i;
      imem_gnt  = reset_n_i & imem_req_i & (~dmem_req_i | (starve_cnt == CNT_MAX));
      dmem_gnt  = reset_n_i & dmem_req_i & ~imem_gnt;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         resp_r     <= RESP_NONE;
         starve_cnt <= '0;
      end else begin
         resp_r     <= resp_next;
         starve_cnt <= starve_cnt_next;
      end
   end

   always_comb begin
      starve_cnt_next = starve_cnt;
      if (imem_gnt || !imem_req_i) begin
         starve_cnt_next = '0;
      end else if (contested && (starve_cnt < CNT_MAX)) begin
         starve_cnt_next = starve_cnt + 1'b1;
      end

      // Writes complete on their grant cycle and never produce a response.
      resp_next = RESP_NONE;
      if (imem_gnt) begin
         resp_next = RESP_IMEM;
      end else if (dmem_gnt && (dmem_wmask_i == 4'b0000)) begin
         resp_next = RESP_DMEM;
      end
   end

   always_comb begin
      imem_gnt_o    = imem_gnt;
      dmem_gnt_o    = dmem_gnt;
      mem_en_o      = imem_gnt | dmem_gnt;
      mem_addr_o    = '0;
      mem_wmask_o   = 4'b0000;
      mem_wdata_o   = 32'h0;
      if (imem_gnt) begin
         mem_addr_o = imem_addr_i;
      end else if (dmem_gnt) begin
         mem_addr_o  = dmem_addr_i;
         mem_wmask_o = dmem_wmask_i;
         mem_wdata_o = dmem_wdata_i;
      end

      imem_rvalid_o = (resp_r == RESP_IMEM);
      dmem_rvalid_o = (resp_r == RESP_DMEM);
      imem_rdata_o  = imem_rvalid_o ? mem_rdata_i : 32'h0;
      dmem_rdata_o  = dmem_rvalid_o ? mem_rdata_i : 32'h0;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inline grant checks plus a read-data scoreboard
// fed by the stimulus and drained by an independent monitor.
module tb_mem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wmask;
   logic        dmem_gnt;
   logic        dmem_rvalid;
   logic [31:0] dmem_rdata;
   logic        mem_en;
   logic [31:0] mem_addr;
   logic [3:0]  mem_wmask;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_i[$];
   logic [31:0] exp_d[$];
   logic [31:0] ram[0:255];

   mem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .imem_req_i    (imem_req),
      .imem_addr_i   (imem_addr),
      .imem_gnt_o    (imem_gnt),
      .imem_rvalid_o (imem_rvalid),
      .imem_rdata_o  (imem_rdata),
      .dmem_req_i    (dmem_req),
      .dmem_addr_i   (dmem_addr),
      .dmem_wdata_i  (dmem_wdata),
      .dmem_wmask_i  (dmem_wmask),
      .dmem_gnt_o    (dmem_gnt),
      .dmem_rvalid_o (dmem_rvalid),
      .dmem_rdata_o  (dmem_rdata),
      .mem_en_o      (mem_en),
      .mem_addr_o    (mem_addr),
      .mem_wmask_o   (mem_wmask),
      .mem_wdata_o   (mem_wdata),
      .mem_rdata_i   (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single-port RAM model: registered read, byte-masked write.
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_wmask == 4'b0000) begin
            mem_rdata <= ram[mem_addr[9:2]];
         end else begin
            for (int b = 0; b < 4; b++) begin
               if (mem_wmask[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic ir, input logic [31:0] ia, input logic dr,
                         input logic [31:0] da, input logic [3:0] dm, input logic [31:0] dw);
      imem_req   = ir;
      imem_addr  = ia;
      dmem_req   = dr;
      dmem_addr  = da;
      dmem_wmask = dm;
      dmem_wdata = dw;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every presented read response must match the oldest expected one.
   always @(negedge clk) begin
      if (reset_n) begin
         if (imem_rvalid) begin
            if (exp_i.size() == 0) chk("imem_rvalid_unexpected", imem_rvalid, 1'b0);
            else begin
               chk("imem_rdata", imem_rdata, exp_i[0]);
               void'(exp_i.pop_front());
            end
         end else begin
            chk("imem_rdata_idle", imem_rdata, 32'h0);
         end
         if (dmem_rvalid) begin
            if (exp_d.size() == 0) chk("dmem_rvalid_unexpected", dmem_rvalid, 1'b0);
            else begin
               chk("dmem_rdata", dmem_rdata, exp_d[0]);
               void'(exp_d.pop_front());
            end
         end else begin
            chk("dmem_rdata_idle", dmem_rdata, 32'h0);
         end
      end
   end

   initial begin
      logic exp_imem;
      for (int a = 0; a < 256; a++) ram[a] = 32'h0;
      ram[8'h40] = 32'hDEADBEEF;   // byte address 0x100
      ram[8'h20] = 32'h11223344;   // byte address 0x080
      ram[8'h10] = 32'hFFFF0000;   // byte address 0x040

      reset_n = 1'b0;
      set_in(1'b1, 32'h100, 1'b1, 32'h80, 4'b0000, 32'h0);
      next_cycle();
      @(negedge clk);
      chk("rst_imem_gnt", imem_gnt, 1'b0);
      chk("rst_dmem_gnt", dmem_gnt, 1'b0);
      chk("rst_mem_en", mem_en, 1'b0);
      chk("rst_imem_rvalid", imem_rvalid, 1'b0);
      chk("rst_dmem_rvalid", dmem_rvalid, 1'b0);
      chk("rst_starve_cnt", dut.starve_cnt, 32'd0);
      next_cycle();

      // imem-only read in the very first cycle out of reset
      reset_n = 1'b1;
      set_in(1'b1, 32'h100, 1'b0, 32'h0, 4'b0000, 32'h0);
      @(negedge clk);
      chk("t1_imem_gnt", imem_gnt, 1'b1);
      chk("t1_dmem_gnt", dmem_gnt, 1'b0);
      chk("t1_mem_addr", mem_addr, 32'h100);
      chk("t1_mem_wmask", mem_wmask, 4'b0000);
      exp_i.push_back(32'hDEADBEEF);
      next_cycle();
      set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
      @(negedge clk);
      chk("t1_imem_rvalid", imem_rvalid, 1'b1);
      chk("idle_mem_en", mem_en, 1'b0);
      chk("idle_mem_addr", mem_addr, 32'h0);
      next_cycle();

      // dmem write: no response; followed by read-back and a back-to-back write
      set_in(1'b0, 32'h0, 1'b1, 32'h40, 4'b0011, 32'h0000ABCD);
      @(negedge clk);
      chk("wr_dmem_gnt", dmem_gnt, 1'b1);
      chk("wr_mem_en", mem_en, 1'b1);
      chk("wr_mem_addr", mem_addr, 32'h40);
      chk("wr_mem_wmask", mem_wmask, 4'b0011);
      chk("wr_mem_wdata", mem_wdata, 32'h0000ABCD);
      next_cycle();
      set_in(1'b0, 32'h0, 1'b1, 32'h40, 4'b0000, 32'h0);
      @(negedge clk);
      chk("wr_no_rvalid", dmem_rvalid, 1'b0);
      chk("rb_dmem_gnt", dmem_gnt, 1'b1);
      exp_d.push_back(32'hFFFFABCD);
      next_cycle();
      set_in(1'b0, 32'h0, 1'b1, 32'h44, 4'b1111, 32'hCAFEF00D);
      @(negedge clk);
      chk("b2b_wr_gnt", dmem_gnt, 1'b1);
      chk("b2b_rd_rvalid", dmem_rvalid, 1'b1);
      next_cycle();

      // imem read then dmem read of 0x80 on consecutive cycles
      set_in(1'b1, 32'h100, 1'b0, 32'h0, 4'b0000, 32'h0);
      @(negedge clk);
      chk("pp_imem_gnt", imem_gnt, 1'b1);
      exp_i.push_back(32'hDEADBEEF);
      next_cycle();
      set_in(1'b0, 32'h0, 1'b1, 32'h80, 4'b0000, 32'h0);
      @(negedge clk);
      chk("pp_dmem_gnt", dmem_gnt, 1'b1);
      chk("pp_imem_rvalid", imem_rvalid, 1'b1);
      exp_d.push_back(32'h11223344);
      next_cycle();
      set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
      @(negedge clk);
      chk("pp_dmem_rvalid", dmem_rvalid, 1'b1);
      next_cycle();

      // Continuous contention: D,D,D,D,I twice; counter 0,1,2,3,4 before each grant
      for (int k = 0; k < 10; k++) begin
         set_in(1'b1, 32'h100, 1'b1, 32'h80, 4'b0000, 32'h5555AAAA);
         exp_imem = ((k % 5) == 4);
         @(negedge clk);
         chk($sformatf("st%0d_cnt", k), dut.starve_cnt, k % 5);
         chk($sformatf("st%0d_imem_gnt", k), imem_gnt, exp_imem);
         chk($sformatf("st%0d_dmem_gnt", k), dmem_gnt, !exp_imem);
         if (exp_imem) begin
            chk($sformatf("st%0d_wdata", k), mem_wdata, 32'h0);
            exp_i.push_back(32'hDEADBEEF);
         end else begin
            exp_d.push_back(32'h11223344);
         end
         next_cycle();
      end

      // Build counter to 3, then imem drops for a cycle and the counter clears
      for (int k = 0; k < 3; k++) begin
         set_in(1'b1, 32'h100, 1'b1, 32'h80, 4'b0000, 32'h0);
         @(negedge clk);
         chk($sformatf("dr%0d_dmem_gnt", k), dmem_gnt, 1'b1);
         exp_d.push_back(32'h11223344);
         next_cycle();
      end
      set_in(1'b0, 32'h0, 1'b1, 32'h80, 4'b0000, 32'h0);
      @(negedge clk);
      chk("dr_cnt3", dut.starve_cnt, 32'd3);
      exp_d.push_back(32'h11223344);
      next_cycle();
      set_in(1'b1, 32'h100, 1'b1, 32'h80, 4'b0000, 32'h0);
      @(negedge clk);
      chk("dr_cnt_cleared", dut.starve_cnt, 32'd0);
      chk("dr_dmem_wins", dmem_gnt, 1'b1);
      chk("dr_imem_loses", imem_gnt, 1'b0);
      exp_d.push_back(32'h11223344);
      next_cycle();

      // Reset right after a dmem read grant discards the pending response
      set_in(1'b1, 32'h100, 1'b1, 32'h80, 4'b0000, 32'h0);
      @(negedge clk);
      chk("rr_dmem_gnt", dmem_gnt, 1'b1);
      next_cycle();
      reset_n = 1'b0;
      @(negedge clk);
      chk("rr_rst_dmem_rvalid", dmem_rvalid, 1'b0);
      chk("rr_rst_imem_gnt", imem_gnt, 1'b0);
      chk("rr_rst_dmem_gnt", dmem_gnt, 1'b0);
      chk("rr_rst_mem_en", mem_en, 1'b0);
      next_cycle();
      reset_n = 1'b1;
      set_in(1'b0, 32'h0, 1'b0, 32'h0, 4'b0000, 32'h0);
      @(negedge clk);
      chk("rr_cnt_after", dut.starve_cnt, 32'd0);
      chk("rr_dmem_rvalid_after", dmem_rvalid, 1'b0);
      next_cycle();
      @(negedge clk);
      chk("rr_dmem_rvalid_later", dmem_rvalid, 1'b0);
      next_cycle();

      next_cycle();
      chk("imem_queue_drained", exp_i.size(), 32'd0);
      chk("dmem_queue_drained", exp_d.size(), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
